// File: rtl/qkv_bram_write_packer.sv
// Packs IN_WIDTH-bit stream beats into DATA_WIDTH-bit words and writes them to
// Port A of the Q/K/V buffer. Define PAD_PARTIAL_EN to zero-fill and write a short final word.
module qkv_bram_write_packer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 256,
  parameter int IN_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  load_done,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic                  err_short
);

  localparam int BEATS  = DATA_WIDTH / IN_WIDTH;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_reg;
  logic [BIDX_W-1:0]     beat_idx_reg;
  logic [DATA_WIDTH-1:0] pack_reg;
  logic                  final_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [CNT_WIDTH-1:0]  num_words_reg;
  logic [CNT_WIDTH-1:0]  words_written_reg;
  logic                  err_short_reg;
  logic                  ena_reg;
  logic [ADDR_WIDTH-1:0] addra_reg;
  logic [DATA_WIDTH-1:0] dina_reg;

  logic [DATA_WIDTH-1:0] packed_next;
  logic                  in_ready_int;
  logic                  accept;
  logic                  word_complete;
  logic                  last_word;

  // The incoming beat replaces its lane; all other lanes hold what was packed so far.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      assign packed_next[gi*IN_WIDTH +: IN_WIDTH] =
        (beat_idx_reg == BIDX_W'(gi)) ? in_data : pack_reg[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  // final_reg marks the cycle the last word is being written, so no further beats are taken.
  assign in_ready_int  = (state_reg == ST_PACK) && !final_reg;
  assign accept        = in_valid && in_ready_int;
  assign word_complete = accept && (beat_idx_reg == LAST_BEAT);
  assign last_word     = (words_written_reg == (num_words_reg - CNT_WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      beat_idx_reg      <= '0;
      pack_reg          <= '0;
      final_reg         <= 1'b0;
      ptr_reg           <= '0;
      num_words_reg     <= '0;
      words_written_reg <= '0;
      err_short_reg     <= 1'b0;
      ena_reg           <= 1'b0;
      addra_reg         <= '0;
      dina_reg          <= '0;
    end else begin
      ena_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_load) begin
            words_written_reg <= '0;
            err_short_reg     <= 1'b0;
            ptr_reg           <= base_addr;
            num_words_reg     <= num_words;
            beat_idx_reg      <= '0;
            pack_reg          <= '0;
            final_reg         <= 1'b0;
            state_reg         <= (num_words != '0) ? ST_PACK : ST_DONE;
          end
        end

        ST_PACK: begin
          if (final_reg) begin
            final_reg <= 1'b0;
            state_reg <= ST_DONE;
          end else if (word_complete) begin
            dina_reg          <= packed_next;
            addra_reg         <= ptr_reg;
            ena_reg           <= 1'b1;
            ptr_reg           <= ptr_reg + ADDR_WIDTH'(1);
            words_written_reg <= words_written_reg + CNT_WIDTH'(1);
            pack_reg          <= '0;
            beat_idx_reg      <= '0;
            if (last_word || in_last) begin
              final_reg <= 1'b1;
            end
            if (in_last && !last_word) begin
              err_short_reg <= 1'b1;
            end
          end else if (accept && in_last) begin
            err_short_reg <= 1'b1;
            pack_reg      <= '0;
            beat_idx_reg  <= '0;
`ifdef PAD_PARTIAL_EN
            // Untouched upper lanes of packed_next are already zero from the per-word clear.
            dina_reg          <= packed_next;
            addra_reg         <= ptr_reg;
            ena_reg           <= 1'b1;
            ptr_reg           <= ptr_reg + ADDR_WIDTH'(1);
            words_written_reg <= words_written_reg + CNT_WIDTH'(1);
            state_reg         <= ST_FLUSH;
`else
            state_reg         <= ST_DONE;
`endif
          end else if (accept) begin
            pack_reg     <= packed_next;
            beat_idx_reg <= beat_idx_reg + BIDX_W'(1);
          end
        end

        ST_FLUSH: begin
          state_reg <= ST_DONE;
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_int;
  assign ena           = ena_reg;
  assign wea           = ena_reg;
  assign addra         = addra_reg;
  assign dina          = dina_reg;
  assign busy          = (state_reg == ST_PACK) || (state_reg == ST_FLUSH);
  assign load_done     = (state_reg == ST_DONE);
  assign words_written = words_written_reg;
  assign err_short     = err_short_reg;

endmodule

// File: tb/tb_qkv_bram_write_packer.sv
// Directed bench for qkv_bram_write_packer: a word-level model predicts every Port A
// write, and a compare process checks each write pulse against it.
module tb_qkv_bram_write_packer;

  localparam int AW    = 16;
  localparam int DW    = 256;
  localparam int IW    = 64;
  localparam int CW    = 16;
  localparam int BEATS = DW / IW;
`ifdef PAD_PARTIAL_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_load;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          load_done;
  logic [CW-1:0] words_written;
  logic          err_short;

  qkv_bram_write_packer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .base_addr(base_addr),
    .num_words(num_words), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .load_done(load_done), .words_written(words_written), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] beat_val(input logic [55:0] tag, input int i);
    return {tag, 8'(i + 1)};
  endfunction

  // Word w of a load, with only the first nvalid lanes carrying beats.
  function automatic logic [DW-1:0] model_word(input logic [55:0] tag, input int w, input int nvalid);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < BEATS; l++)
      if (l < nvalid) r[l*IW +: IW] = beat_val(tag, w*BEATS + l);
    return r;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int w);
    return base + AW'(w);
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ena || wea)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addra=%h dina=%h expected no write", addra, dina);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write addr=%h data=%h", addra, dina);
        chk("write_enables", {ena, wea}, 2'b11);
        chk("addra", addra, e.addr);
        chk("dina", dina, e.data);
      end
    end
  end

  task automatic do_load(input string nm, input logic [AW-1:0] base, input logic [CW-1:0] nw,
                         input int last_at, input bit gap, input bit poke,
                         input logic [55:0] tag, input int abort_at);
    int  full, acc, nwr, part, end_c, exp_done, idx, guard;
    bit  toggle, poked, got, exp_err;
    full = int'(nw) * BEATS;
    acc  = (last_at != 0 && last_at < full) ? last_at : full;
    if (abort_at != 0) acc = abort_at;
    exp_err = (last_at != 0 && last_at < full);
    nwr  = acc / BEATS;
    part = acc % BEATS;
    for (int w = 0; w < nwr; w++)
      exp_q.push_back('{model_addr(base, w), model_word(tag, w, BEATS)});
    if (part != 0 && PAD && abort_at == 0) begin
      exp_q.push_back('{model_addr(base, nwr), model_word(tag, nwr, part)});
      nwr++;
    end

    @(negedge clk);
    start_load = 1'b1; base_addr = base; num_words = nw;
    @(negedge clk);
    start_load = 1'b0; base_addr = 16'hDEAD; num_words = 16'd7;

    idx = 0; guard = 0; toggle = 1'b1; poked = 1'b0;
    while (idx < acc && guard < 200) begin
      in_valid = gap ? toggle : 1'b1;
      toggle   = !toggle;
      in_data  = beat_val(tag, idx);
      in_last  = (last_at != 0 && idx + 1 == last_at);
      if (poke && idx == 2 && !poked) begin
        start_load = 1'b1; base_addr = 16'h7777; num_words = 16'd9; poked = 1'b1;
      end else begin
        start_load = 1'b0;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    start_load = 1'b0;
    if (guard >= 200) chk({nm, "_beat_timeout"}, 1'b1, 1'b0);
    end_c = cyc;

    if (abort_at != 0) begin
      rst_n = 1'b0;
      #1;
      chk({nm, "_rst_ena"}, {ena, wea}, 2'b00);
      chk({nm, "_rst_addra"}, addra, '0);
      chk({nm, "_rst_dina"}, dina, '0);
      chk({nm, "_rst_flags"}, {in_ready, busy, load_done, err_short}, 4'b0000);
      chk({nm, "_rst_words"}, words_written, '0);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk({nm, "_writes_before_abort"}, exp_q.size(), 0);
      exp_q.delete();
      $display("load %s aborted after %0d beats", nm, acc);
      return;
    end

    in_data = beat_val(tag, 99);
    in_last = 1'b0;
    chk({nm, "_in_ready_drop"}, in_ready, 1'b0);
    in_valid = 1'b0;

    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (load_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp_done = (acc == 0 || (part != 0 && !PAD)) ? end_c : end_c + 1;
    chk({nm, "_done_seen"}, got, 1'b1);
    if (got) chk({nm, "_done_cycle"}, cyc, exp_done);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    chk({nm, "_done_width"}, load_done, 1'b0);
    chk({nm, "_words_written"}, words_written, nwr);
    chk({nm, "_err_short"}, err_short, exp_err);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    $display("load %s base=%h words=%0d beats=%0d writes=%0d err=%0d", nm, base, nw, acc, nwr, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; start_load = 1'b0; base_addr = '0; num_words = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;

    // Pin the model against hand-computed words and addresses.
    chk("model_word0", model_word(56'h0, 0, 4),
        256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
    chk("model_pad_word", model_word(56'h0, 1, 2),
        256'h0000000000000000_0000000000000000_0000000000000006_0000000000000005);
    chk("model_wrap_addr", model_addr(16'hFFFF, 1), 16'h0000);

    repeat (3) @(negedge clk);
    chk("reset_ena", {ena, wea}, 2'b00);
    chk("reset_flags", {in_ready, busy, load_done, err_short}, 4'b0000);
    chk("reset_addra_words", {addra, words_written}, '0);
    chk("reset_dina", dina, '0);
    rst_n = 1'b1;

    do_load("basic",     16'h0010, 16'd2, 0, 1'b0, 1'b0, 56'h0,              0);
    do_load("gap_poke",  16'h0010, 16'd2, 0, 1'b1, 1'b1, 56'h0,              0);
    do_load("wrap",      16'hFFFF, 16'd2, 0, 1'b0, 1'b0, 56'hA1B2C3D4E5F607, 0);
    do_load("early",     16'h0040, 16'd3, 6, 1'b0, 1'b0, 56'h0,              0);
    do_load("exact",     16'h0050, 16'd1, 4, 1'b1, 1'b0, 56'h55AA55AA55AA55, 0);
    do_load("zero",      16'h0060, 16'd0, 0, 1'b0, 1'b0, 56'h0,              0);
    do_load("abort",     16'h0200, 16'd2, 0, 1'b0, 1'b0, 56'h22,             5);
    do_load("post_rst",  16'h0300, 16'd1, 0, 1'b0, 1'b0, 56'h33,             0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qkv_bram_write_packer.md
Name: qkv_bram_write_packer

Overview:
Upstream load stage for the Q/K/V dual-port buffer. Accepts a narrow valid/ready stream of quantized activations and packs IN_WIDTH-bit beats into DATA_WIDTH-bit words. Drives the buffer's Port A (ena/wea/addra/dina) with sequential addresses from a programmable base. Signals load completion so the controller can start the Port B fetch.

Parameters:
ADDR_WIDTH, 16, Port A address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 256, BRAM word width
IN_WIDTH, 64, stream beat width; DATA_WIDTH must be an integer multiple (BEATS = DATA_WIDTH/IN_WIDTH = 4)
CNT_WIDTH, 16, width of word-count port and counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_load  in  1  pulse; latches base_addr/num_words; ignored while busy=1
base_addr  in  ADDR_WIDTH  first write address
num_words  in  CNT_WIDTH  BRAM words to write this load
in_data  in  IN_WIDTH  stream beat
in_valid  in  1  beat valid
in_last  in  1  final beat of stream (qualified by in_valid&in_ready)
in_ready  out  1  beat accept
ena  out  1  Port A enable
wea  out  1  Port A write enable
addra  out  ADDR_WIDTH  Port A address
dina  out  DATA_WIDTH  Port A write data
busy  out  1  load in progress
load_done  out  1  one-cycle completion pulse
words_written  out  CNT_WIDTH  words written in current/last load
err_short  out  1  sticky: in_last before num_words reached; cleared by start_load

Behaviour:
- Reset: all outputs 0, state IDLE, beat index 0, pack register 0.
- States: IDLE, PACK, FLUSH, DONE.
- IDLE: in_ready=0, busy=0. start_load with num_words>0 -> PACK; clear words_written/err_short; address pointer = base_addr. start_load with num_words=0 -> DONE, no writes.
- PACK: in_ready=1, busy=1. Each accepted beat is stored at lane beat_idx (beat 0 -> dina[IN_WIDTH-1:0], little-endian lanes); beat_idx increments.
- Word write: the beat completing a word (beat_idx=BEATS-1) is accepted in cycle N. In cycle N+1, ena=wea=1 for exactly one cycle, with addra=pointer and dina=the packed word. Pointer then increments, wrapping at 2^ADDR_WIDTH. words_written increments in N+1. The output register is separate from the pack register, so in_ready stays high. Throughput is 1 beat/cycle.
- Final word: when the completing beat of word num_words-1 is accepted, in_ready drops the next cycle. After the N+1 write, go to DONE.
- in_last on the exact final beat: normal completion, no error. Reaching num_words without in_last is also normal.
- in_last accepted before num_words is reached: err_short=1. Partial-word handling is per the optional feature. Then go to DONE; no further beats accepted.
- DONE: load_done=1 for one cycle, busy=0; return to IDLE next cycle.
- ena/wea are never asserted outside a word write.
- start_load while busy: ignored, no effect.
- rst_n low mid-load: immediate abort to reset values; partial data discarded; no load_done.

Optional Feature:
PAD_PARTIAL_EN
- Defined: in_last accepted with beat_idx≠BEATS-1 -> FLUSH. The remaining lanes are zero-filled and the word is written one cycle after in_last acceptance; words_written counts it. Then DONE.
- Undefined: the partial word is discarded with no write, FLUSH is unreachable, and err_short is still set.

Test Plan:
- Basic: base_addr=0x0010, num_words=2, 8 beats 0x..01..0x..08 back-to-back -> writes at 0x0010 (lanes 4,3,2,1 with beat1 in LSBs) and 0x0011. load_done one cycle after the second write; words_written=2; err_short=0.
- Backpressure gaps: same load with in_valid toggling every other cycle -> identical write data/addresses; exactly one write pulse per 4 accepted beats.
- Wrap: base_addr=0xFFFF, num_words=2 -> writes at 0xFFFF then 0x0000.
- Early in_last: num_words=3, in_last on beat 6 -> err_short=1. With PAD_PARTIAL_EN: second word has lanes 2,3 zero and words_written=2. Without it: words_written=1 and no second write. load_done pulses in both cases.
- Zero/ignore: num_words=0 -> load_done next cycle, ena never high. start_load during PACK -> no change to address or count.
- Reset mid-load: rst_n low after 5 beats -> all outputs 0 immediately. A new load after release starts cleanly at its own base_addr.
